// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader and its
// host-link helpers: state encoding, word geometry and a state decode helper.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // States in which the loader is consuming host bytes.
    function automatic logic is_busy(input state_t s);
        return (s == HDR) || (s == LOAD) || (s == CHK);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses in
// the cycle the fourth byte of a word is accepted, with word already complete.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int SH_W = WORD_W - 8;

    logic [1:0]      cnt_r;
    logic [SH_W-1:0] shift_r;

    // Byte counter and shift register; earlier bytes move toward the LSBs.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r   <= 2'd0;
            shift_r <= {SH_W{1'b0}};
        end else if (byte_valid) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {byte_data, shift_r[SH_W-1:8]};
        end
    end

    assign word_valid = byte_valid && (cnt_r == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, shift_r};

endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed program image from a host byte stream into IMEM and
// releases the core once complete. IMEM_LOADER_CHECKSUM_EN adds a trailing sum word.
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [WORD_W:0]   CAPACITY = {{WORD_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [ADDR_W:0]   ONE_W    = {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST_LOAD = CHK;
`else
    localparam state_t POST_LOAD = DONE;
`endif

    state_t              state_r, next_state_s;
    logic                active_r, done_r, err_r, wen_r;
    logic [ADDR_W-1:0]   waddr_r;
    logic [WORD_W-1:0]   wdata_r;
    logic [ADDR_W:0]     wl_r, n_words_r;
    logic                byte_fire_s, word_valid_s, restart_s, enter_hdr_s;
    logic                load_word_s, last_word_s;
    logic [WORD_W-1:0]   word_s;

    assign byte_fire_s = in_valid && active_r;
    assign restart_s   = start && !is_busy(state_r);
    assign enter_hdr_s = (next_state_s == HDR) && (state_r != HDR);
    assign load_word_s = (state_r == LOAD) && word_valid_s;
    assign last_word_s = load_word_s && (wl_r == (n_words_r - ONE_W));

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart_s),
        .byte_valid (byte_fire_s),
        .byte_data  (in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_r;

    // Running sum of data words, restarted for every new image.
    always_ff @(posedge clk) begin
        if (rst || enter_hdr_s) begin
            sum_r <= {WORD_W{1'b0}};
        end else if (load_word_s) begin
            sum_r <= sum_r + word_s;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = HDR;
                else       next_state_s = IDLE;
            end
            HDR: begin
                if (!word_valid_s)                      next_state_s = HDR;
                else if (word_s == 32'd0)               next_state_s = POST_LOAD;
                else if ({1'b0, word_s} > CAPACITY)     next_state_s = ERR;
                else                                    next_state_s = LOAD;
            end
            LOAD: begin
                if (last_word_s) next_state_s = POST_LOAD;
                else             next_state_s = LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (!word_valid_s)          next_state_s = CHK;
                else if (word_s == sum_r)   next_state_s = DONE;
                else                        next_state_s = ERR;
            end
`endif
            DONE, ERR: begin
                if (start) next_state_s = HDR;
                else       next_state_s = state_r;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State and status flags; done/err follow one cycle after the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            active_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            active_r <= is_busy(next_state_s);
            done_r   <= (state_r == DONE) && (next_state_s == DONE);
            err_r    <= (state_r == ERR) && (next_state_s == ERR);
        end
    end

    // IMEM write port, word counter and captured header length.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_r     <= 1'b0;
            waddr_r   <= {ADDR_W{1'b0}};
            wdata_r   <= {WORD_W{1'b0}};
            wl_r      <= {(ADDR_W+1){1'b0}};
            n_words_r <= {(ADDR_W+1){1'b0}};
        end else begin
            wen_r <= load_word_s;
            if (load_word_s) begin
                waddr_r <= BASE_A + wl_r[ADDR_W-1:0];
                wdata_r <= word_s;
            end
            if (enter_hdr_s) begin
                wl_r <= {(ADDR_W+1){1'b0}};
            end else if (load_word_s) begin
                wl_r <= wl_r + ONE_W;
            end
            if ((state_r == HDR) && word_valid_s) begin
                n_words_r <= word_s[ADDR_W:0];
            end
        end
    end

    assign in_ready     = active_r;
    assign busy         = active_r;
    assign done         = done_r;
    assign core_en      = done_r;
    assign err          = err_r;
    assign imem_wen     = wen_r;
    assign imem_waddr   = waddr_r;
    assign imem_wdata   = wdata_r;
    assign words_loaded = wl_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader (ADDR_W=4): normal, empty, oversize,
// full-capacity, gapped and reset-interrupted loads, plus checksum cases when enabled.
module tb_imem_program_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, imem_wen, core_en, busy, done, err;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wen     (imem_wen),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_en      (core_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_wen === 1'b1) wr_count <= wr_count + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 64'(t < 20), 64'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_chk(input logic [31:0] c, input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(c, gap);
`else
        if (gap && c == 32'hFFFF_FFFF) @(negedge clk);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_write(input int idx, input logic [31:0] data);
        chk("wen", 64'(imem_wen), 64'd1);
        chk("waddr", 64'(imem_waddr), 64'(idx));
        chk("wdata", 64'(imem_wdata), 64'(data));
        chk("words_loaded", 64'(words_loaded), 64'(idx + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_wen"}, 64'(imem_wen), 64'd0);
        chk({tag, "_waddr"}, 64'(imem_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_core_en"}, 64'(core_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic check_done(input int n);
        chk("done", 64'(done), 64'd1);
        chk("core_en", 64'(core_en), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("in_ready_done", 64'(in_ready), 64'd0);
        chk("words_done", 64'(words_loaded), 64'(n));
    endtask

    initial begin
        logic [31:0] w3 [3];
        logic [31:0] sum, w;
        int n0;
        w3[0] = 32'h1122_3344;
        w3[1] = 32'hAABB_CCDD;
        w3[2] = 32'h0000_0001;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-word image, gap-free.
        pulse_start();
        chk("hdr_busy", 64'(busy), 64'd1);
        chk("hdr_ready", 64'(in_ready), 64'd1);
        send_word(32'd3, 1'b0);
        chk("hdr_no_wen", 64'(imem_wen), 64'd0);
        sum = 32'd0;
        for (int i = 0; i < 3; i++) begin
            send_word(w3[i], 1'b0);
            check_write(i, w3[i]);
            chk("done_early", 64'(done), 64'd0);
            sum += w3[i];
        end
        send_chk(sum, 1'b0);
        @(negedge clk);
        check_done(3);
        chk("wen_after", 64'(imem_wen), 64'd0);

        // Empty image.
        n0 = wr_count;
        pulse_start();
        chk("restart_done_clr", 64'(done), 64'd0);
        chk("restart_core_clr", 64'(core_en), 64'd0);
        chk("restart_words_clr", 64'(words_loaded), 64'd0);
        send_word(32'd0, 1'b0);
        send_chk(32'd0, 1'b0);
        @(negedge clk);
        check_done(0);
        chk("n0_no_writes", 64'(wr_count), 64'(n0));

        // Same image with random in_valid gaps and a stray start mid-load.
        pulse_start();
        send_word(32'd3, 1'b1);
        sum = 32'd0;
        for (int i = 0; i < 3; i++) begin
            send_word(w3[i], 1'b1);
            check_write(i, w3[i]);
            sum += w3[i];
            if (i == 0) begin
                pulse_start();
                chk("stray_start_busy", 64'(busy), 64'd1);
                chk("stray_start_ready", 64'(in_ready), 64'd1);
            end
        end
        send_chk(sum, 1'b1);
        @(negedge clk);
        check_done(3);

        // Oversized header aborts, then a fresh load recovers.
        n0 = wr_count;
        pulse_start();
        send_word(32'd17, 1'b0);
        @(negedge clk);
        chk("err", 64'(err), 64'd1);
        chk("err_ready", 64'(in_ready), 64'd0);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_core_en", 64'(core_en), 64'd0);
        chk("err_no_writes", 64'(wr_count), 64'(n0));
        pulse_start();
        chk("err_clr", 64'(err), 64'd0);
        send_word(32'd1, 1'b0);
        send_word(32'h5A5A_A5A5, 1'b0);
        check_write(0, 32'h5A5A_A5A5);
        send_chk(32'h5A5A_A5A5, 1'b0);
        @(negedge clk);
        check_done(1);

        // Full capacity (N == 2**ADDR_W) is accepted.
        pulse_start();
        send_word(32'd16, 1'b0);
        sum = 32'd0;
        for (int i = 0; i < 16; i++) begin
            w = 32'h0101_0101 * (i + 1);
            send_word(w, 1'b0);
            check_write(i, w);
            sum += w;
        end
        send_chk(sum, 1'b0);
        @(negedge clk);
        check_done(16);

        // Reset after six data bytes; partial word is discarded.
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd1);
        send_word(32'd1, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        check_write(0, 32'hCAFE_F00D);
        send_chk(32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        check_done(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        check_write(0, 32'd1);
        send_word(32'd2, 1'b0);
        check_write(1, 32'd2);
        send_word(32'd3, 1'b0);
        @(negedge clk);
        check_done(2);
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        @(negedge clk);
        chk("chk_err", 64'(err), 64'd1);
        chk("chk_core_en", 64'(core_en), 64'd0);
        chk("chk_done", 64'(done), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
